// File: rtl/phase_extract_cordic_pkg.sv
// Shared constants and helpers for the vectoring-mode CORDIC phase extractor.
// Angles and the gain constant are held at Q30 and rounded to the working FRAC.
package phase_extract_cordic_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FOLD, S_ITER, S_SCALE, S_DONE} state_t;

    localparam int     Q            = 30;
    localparam longint HALF_PI_Q30  = 64'sd1686629713;
    localparam longint PI_Q30       = 64'sd3373259426;
    localparam longint CORDIC_K_Q30 = 64'sd652032875;

    function automatic longint q30_to_fx(input longint v, input int frac);
        return (v + (64'sd1 <<< (Q - 1 - frac))) >>> (Q - frac);
    endfunction

    // atan(2^-k) at Q30; beyond k=9 the small-angle value 2^-k is exact to Q30
    function automatic longint atan_q30(input int k);
        case (k)
            0:       return 64'sd843314857;
            1:       return 64'sd497837829;
            2:       return 64'sd263043837;
            3:       return 64'sd133525159;
            4:       return 64'sd67021687;
            5:       return 64'sd33543516;
            6:       return 64'sd16775851;
            7:       return 64'sd8388437;
            8:       return 64'sd4194283;
            9:       return 64'sd2097149;
            default: return (k > Q) ? 64'sd0 : (64'sd1 <<< (Q - k));
        endcase
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: k -> atan(2^-k) in FRAC format, k < ITER.
module cordic_atan_rom import phase_extract_cordic_pkg::*; #(
    parameter int FRAC = 12,
    parameter int ITER = 16,
    parameter int ZW   = 17,
    parameter int KW   = 4
) (
    input  logic [KW-1:0]        k,
    output logic signed [ZW-1:0] atan
);

    always_comb begin
        atan = '0;
        for (int i = 0; i < ITER; i++)
            if (k == KW'(i)) atan = ZW'(q30_to_fx(atan_q30(i), FRAC));
    end

endmodule

// File: rtl/phase_extract_cordic.sv
// Rectangular-to-polar converter: iterative vectoring CORDIC, one micro-rotation
// per clock, valid/ready on both sides.
module phase_extract_cordic import phase_extract_cordic_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic signed [WIDTH-1:0] in_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] mag,
    output logic signed [WIDTH-1:0] phase,
    output logic                    zero_in
);

    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;
    localparam int PW = 2 * XW;
    localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [ZW-1:0] HALF_PI  = ZW'(q30_to_fx(HALF_PI_Q30, FRAC));
    localparam logic signed [ZW-1:0] PI       = ZW'(q30_to_fx(PI_Q30, FRAC));
    localparam logic signed [XW-1:0] CORDIC_K = XW'(q30_to_fx(CORDIC_K_Q30, FRAC));
    localparam logic signed [PW-1:0] MAG_MAX  = PW'({1'b0, {(WIDTH-1){1'b1}}});

    state_t                state, state_nx;
    logic [KW-1:0]         k;
    logic signed [XW-1:0]  x, y, x_sh, y_sh;
    logic signed [ZW-1:0]  z, atan, z_fix;
    logic signed [PW-1:0]  prod, scaled;
    logic signed [WIDTH-1:0] mag_sat;

    cordic_atan_rom #(.FRAC(FRAC), .ITER(ITER), .ZW(ZW), .KW(KW)) u_rom (
        .k    (k),
        .atan (atan)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_FOLD;
            S_FOLD:  state_nx = S_ITER;
            S_ITER:  if (k == KW'(ITER - 1)) state_nx = S_SCALE;
            S_SCALE: state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    assign x_sh = x >>> k;
    assign y_sh = y >>> k;

    // Undo the CORDIC gain, then clamp only at the output word
    always_comb begin
        prod   = PW'(x) * PW'(CORDIC_K);
        scaled = prod >>> FRAC;
        if (scaled < 0)             mag_sat = '0;
        else if (scaled > MAG_MAX)  mag_sat = WIDTH'(MAG_MAX);
        else                        mag_sat = WIDTH'(scaled);
        z_fix = (z == -PI) ? PI : z;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            k       <= '0;
            mag     <= '0;
            phase   <= '0;
            zero_in <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x <= XW'(in_r);
                    y <= XW'(in_i);
                    k <= '0;
                end
                S_FOLD: begin
                    zero_in <= (x == '0) && (y == '0);
                    // Left half-plane is rotated by 90 degrees so the iterations converge
                    if (x < 0 && y >= 0) begin
                        x <= y;
                        y <= -x;
                        z <= HALF_PI;
                    end else if (x < 0) begin
                        x <= -y;
                        y <= x;
                        z <= -HALF_PI;
                    end else begin
                        z <= '0;
                    end
                end
                S_ITER: begin
                    if (!y[XW-1]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan;
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan;
                    end
                    k <= k + KW'(1);
                end
                S_SCALE: begin
                    if (zero_in) begin
                        mag   <= '0;
                        phase <= '0;
                    end else begin
                        mag   <= mag_sat;
                        phase <= WIDTH'(z_fix);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_extract_cordic.sv
// Directed bench for phase_extract_cordic (WIDTH=16, FRAC=12, ITER=16).
module tb_phase_extract_cordic;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready, zero_in;
    logic signed [15:0] in_r, in_i, mag, phase;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_extract_cordic #(.WIDTH(16), .FRAC(12), .ITER(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag       (mag),
        .phase     (phase),
        .zero_in   (zero_in)
    );

    typedef struct {
        int r;
        int i;
        int emag;
        int eph;
        int ezero;
    } vec_t;

    vec_t vecs[9] = '{
        '{4096,      0,  4096,      0, 0},
        '{   0,   4096,  4096,   6434, 0},
        '{   0,  -4096,  4096,  -6434, 0},
        '{-4096,     0,  4096,  12868, 0},
        '{-4096,    -1,  4096, -12867, 0},
        '{2896,   2896,  4096,   3217, 0},
        '{32767, 32767, 32767,   3217, 0},
        '{   0,      0,     0,      0, 1},
        '{3595,   1964,  4096,   2048, 0}   // (4096,0) rotated by 0.5 rad
    };

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_cmp++;
        if (got < exp - tol || got > exp + tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (+-%0d)", tag, got, exp, tol);
        end
    endtask

    task automatic send(input int r, input int i);
        @(negedge clk);
        in_r     = 16'(r);
        in_i     = 16'(i);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_r     = 16'sd0;
        in_i     = 16'sd0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pop_in_ready", int'(in_ready), 1, 0);
        check("pop_out_valid", int'(out_valid), 0, 0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_r      = '0;
        in_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_mag", int'(mag), 0, 0);
        check("rst_phase", int'(phase), 0, 0);
        check("rst_zero_in", int'(zero_in), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors: each pop is followed directly by the next accept
        foreach (vecs[n]) begin
            send(vecs[n].r, vecs[n].i);
            check($sformatf("v%0d_busy", n), int'(in_ready), 0, 0);
            wait_out(lat);
            if (n == 0) check("latency", lat, 18, 0);
            check($sformatf("v%0d_valid", n), int'(out_valid), 1, 0);
            check($sformatf("v%0d_mag", n), int'(mag), vecs[n].emag, (n == 6) ? 0 : 3);
            check($sformatf("v%0d_phase", n), int'(phase), vecs[n].eph, 3);
            check($sformatf("v%0d_zero", n), int'(zero_in), vecs[n].ezero, 0);
            pop();
        end

        // Backpressure: result held while out_ready low, new input ignored
        send(2896, 2896);
        wait_out(lat);
        @(negedge clk);
        in_r     = 16'sd100;
        in_i     = 16'sd0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", c), int'(out_valid), 1, 0);
            check($sformatf("hold%0d_ready", c), int'(in_ready), 0, 0);
            check($sformatf("hold%0d_mag", c), int'(mag), 4096, 3);
            check($sformatf("hold%0d_phase", c), int'(phase), 3217, 3);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop();

        // Reset in the middle of the iterations discards the operation
        send(4096, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", int'(out_valid), 0, 0);
        check("midrst_in_ready", int'(in_ready), 1, 0);
        check("midrst_mag", int'(mag), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_idle_valid", int'(out_valid), 0, 0);

        send(0, 4096);
        wait_out(lat);
        check("post_rst_latency", lat, 18, 0);
        check("post_rst_phase", int'(phase), 6434, 3);
        check("post_rst_mag", int'(mag), 4096, 3);
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
